// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and constants for the ATM transaction engine
package atm_pkg;

  localparam int N_ACC    = 10;
  localparam int INIT_BAL = 1000;
  localparam int MAX_FAIL = 3;
  localparam int MAX_PIN  = 9999;
  localparam int IDX_W    = $clog2(N_ACC);
  localparam int FAIL_W   = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WITHDRAW = 3'd1,
    OP_CHG_PIN  = 3'd2,
    OP_BALANCE  = 3'd3,
    OP_NOP4     = 3'd4,
    OP_DEPOSIT  = 3'd5,
    OP_EXIT     = 3'd6,
    OP_NOP7     = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WITHDRAW = 3'd1,
    ST_CHG_PIN  = 3'd2,
    ST_BALANCE  = 3'd3,
    ST_DEPOSIT  = 3'd5,
    ST_ERROR    = 3'd6,
    ST_RESET    = 3'd7
  } state_e;

  // Entry i holds the factory PIN of account i+1
  localparam logic [15:0] DEFAULT_PIN [N_ACC] = '{
    16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
    16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
  };

  // State a successful request of this op settles in; used to detect held requests
  function automatic state_e target_state(op_e op);
    case (op)
      OP_WITHDRAW: return ST_WITHDRAW;
      OP_CHG_PIN:  return ST_CHG_PIN;
      OP_BALANCE:  return ST_BALANCE;
      OP_DEPOSIT:  return ST_DEPOSIT;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/atm_if.sv
// rtl/atm_if.sv - request/result bundle between the UI layer and atm_core
interface atm_if;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] newPin;
  logic [31:0] amount;
  logic        language;
  logic [31:0] balance;
  logic        success;
  logic [2:0]  state;
  logic        language_q;

  modport master (
    output operation, acc_num, pin, newPin, amount, language,
    input  balance, success, state, language_q
  );

  modport slave (
    input  operation, acc_num, pin, newPin, amount, language,
    output balance, success, state, language_q
  );
endinterface

// File: rtl/atm_auth.sv
// rtl/atm_auth.sv - PIN table, wrong-PIN counters and account locks
module atm_auth
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       acc_num,
  input  logic [15:0]      pin,
  input  logic             fail_inc,
  input  logic             fail_clr,
  input  logic             pin_wr,
  input  logic [15:0]      new_pin,
  output logic             acc_valid,
  output logic             locked,
  output logic             pin_ok,
  output logic             auth,
  output logic [IDX_W-1:0] acc_idx
);

  logic [15:0]       pin_tab  [N_ACC];
  logic [FAIL_W-1:0] fail_cnt [N_ACC];
  logic              lock     [N_ACC];

  assign acc_valid = (acc_num != 4'd0) && (acc_num <= 4'(N_ACC));
  // Invalid numbers alias slot 0; callers always gate on acc_valid first
  assign acc_idx   = acc_valid ? IDX_W'(acc_num - 4'd1) : '0;
  assign locked    = lock[acc_idx];
  assign pin_ok    = (pin_tab[acc_idx] == pin);
  assign auth      = acc_valid && !locked && pin_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ACC; i++) begin
        pin_tab[i]  <= DEFAULT_PIN[i];
        fail_cnt[i] <= '0;
        lock[i]     <= 1'b0;
      end
    end else begin
      if (pin_wr) begin
        pin_tab[acc_idx] <= new_pin;
      end
      if (fail_clr) begin
        fail_cnt[acc_idx] <= '0;
      end else if (fail_inc) begin
        fail_cnt[acc_idx] <= fail_cnt[acc_idx] + 1'b1;
        if (fail_cnt[acc_idx] == FAIL_W'(MAX_FAIL - 1)) begin
          lock[acc_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/atm_core.sv
// rtl/atm_core.sv - ATM transaction engine: authenticate, execute once, register results
module atm_core
  import atm_pkg::*;
(
  input logic  clk,
  input logic  rst,
  atm_if.slave bus
);

  op_e              op;
  state_e           state_q, nxt_state;
  logic             success_q, nxt_success;
  logic [31:0]      balance_q, nxt_balance;
  logic [3:0]       prev_acc;
  op_e              prev_op;
  logic             lang_q;
  logic [31:0]      bal_tab [N_ACC];

  logic             acc_valid, locked, pin_ok, auth;
  logic [IDX_W-1:0] acc_idx;
  logic             fail_inc, fail_clr, pin_wr, bal_wr;
  logic [31:0]      bal_wdata, cur_bal;
  logic [32:0]      dep_sum;
  logic             fresh;

  assign op = op_e'(bus.operation);

  atm_auth u_auth (
    .clk       (clk),
    .rst       (rst),
    .acc_num   (bus.acc_num),
    .pin       (bus.pin),
    .fail_inc  (fail_inc),
    .fail_clr  (fail_clr),
    .pin_wr    (pin_wr),
    .new_pin   (bus.newPin),
    .acc_valid (acc_valid),
    .locked    (locked),
    .pin_ok    (pin_ok),
    .auth      (auth),
    .acc_idx   (acc_idx)
  );

  assign cur_bal = bal_tab[acc_idx];
  assign dep_sum = {1'b0, cur_bal} + {1'b0, bus.amount};
  // A held request (same op, same account, already in its target state) is not re-run
  assign fresh   = (state_q != target_state(op)) || (bus.acc_num != prev_acc) || (op != prev_op);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= nxt_state;
    end
  end

  always_comb begin
    nxt_state   = state_q;
    nxt_success = success_q;
    nxt_balance = balance_q;
    bal_wr      = 1'b0;
    bal_wdata   = cur_bal;
    fail_inc    = 1'b0;
    fail_clr    = 1'b0;
    pin_wr      = 1'b0;
    if (fresh) begin
      if (op == OP_NOP || op == OP_NOP4 || op == OP_NOP7) begin
        nxt_state   = ST_IDLE;
        nxt_success = 1'b0;
        nxt_balance = auth ? cur_bal : 32'd0;
      end else if (!acc_valid || locked || !pin_ok) begin
        nxt_state   = ST_ERROR;
        nxt_success = 1'b0;
        nxt_balance = 32'd0;
        fail_inc    = acc_valid && !locked;
      end else begin
        fail_clr    = 1'b1;
        nxt_balance = cur_bal;
        nxt_state   = ST_ERROR;
        nxt_success = 1'b0;
        case (op)
          OP_WITHDRAW: if (bus.amount <= cur_bal) begin
            bal_wr      = 1'b1;
            bal_wdata   = cur_bal - bus.amount;
            nxt_balance = bal_wdata;
            nxt_state   = ST_WITHDRAW;
            nxt_success = 1'b1;
          end
          OP_DEPOSIT: if (!dep_sum[32]) begin
            bal_wr      = 1'b1;
            bal_wdata   = dep_sum[31:0];
            nxt_balance = bal_wdata;
            nxt_state   = ST_DEPOSIT;
            nxt_success = 1'b1;
          end
          OP_CHG_PIN: if (bus.newPin <= 16'(MAX_PIN)) begin
            pin_wr      = 1'b1;
            nxt_state   = ST_CHG_PIN;
            nxt_success = 1'b1;
          end
          OP_BALANCE: begin
            nxt_state   = ST_BALANCE;
            nxt_success = 1'b1;
          end
          default: begin
            nxt_state   = ST_IDLE;
            nxt_success = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      success_q <= 1'b0;
      balance_q <= 32'd0;
      prev_acc  <= 4'd0;
      prev_op   <= OP_NOP;
      lang_q    <= 1'b0;
      for (int i = 0; i < N_ACC; i++) begin
        bal_tab[i] <= 32'(INIT_BAL);
      end
    end else begin
      success_q <= nxt_success;
      balance_q <= nxt_balance;
      prev_acc  <= bus.acc_num;
      prev_op   <= op;
      lang_q    <= bus.language;
      if (bal_wr) begin
        bal_tab[acc_idx] <= bal_wdata;
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.success    = success_q;
  assign bus.balance    = balance_q;
  assign bus.language_q = lang_q;

endmodule

// File: tb/tb_atm_core.sv
// tb/tb_atm_core.sv - directed and randomized bench for atm_core against a ledger model
module tb_atm_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  atm_if bus ();

  atm_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Ledger model: accounts indexed by their number, slots 0 and 11..15 unused
  longint m_bal  [0:15];
  int     m_pin  [0:15];
  int     m_fail [0:15];
  bit     m_lock [0:15];
  int     m_state, m_prev_acc, m_prev_op;
  bit     m_success;
  longint m_balance;

  task automatic model_reset();
    int defaults [10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
    for (int a = 0; a < 16; a++) begin
      m_bal[a]  = 1000;
      m_pin[a]  = (a >= 1 && a <= 10) ? defaults[a-1] : -1;
      m_fail[a] = 0;
      m_lock[a] = 1'b0;
    end
    m_state = 7; m_success = 1'b0; m_balance = 0;
    m_prev_acc = 0; m_prev_op = 0;
  endtask

  task automatic model_step(input int op, input int acc, input int pn, input int npn, input longint amt);
    int  tgt;
    bit  fresh, valid, ok;
    tgt   = (op inside {1, 2, 3, 5}) ? op : 0;
    fresh = (m_state != tgt) || (acc != m_prev_acc) || (op != m_prev_op);
    m_prev_acc = acc;
    m_prev_op  = op;
    if (!fresh) return;
    valid = (acc >= 1 && acc <= 10);
    ok    = valid && !m_lock[acc] && (pn == m_pin[acc]);
    if (op inside {0, 4, 7}) begin
      m_state = 0; m_success = 0; m_balance = ok ? m_bal[acc] : 0;
      return;
    end
    if (!ok) begin
      if (valid && !m_lock[acc]) begin
        m_fail[acc]++;
        if (m_fail[acc] >= 3) m_lock[acc] = 1'b1;
      end
      m_state = 6; m_success = 0; m_balance = 0;
      return;
    end
    m_fail[acc] = 0;
    m_state = 6; m_success = 0;
    case (op)
      1: if (amt <= m_bal[acc]) begin m_bal[acc] -= amt; m_state = 1; m_success = 1; end
      5: if (m_bal[acc] + amt <= longint'(32'hFFFF_FFFF)) begin m_bal[acc] += amt; m_state = 5; m_success = 1; end
      2: if (npn <= 9999) begin m_pin[acc] = npn; m_state = 2; m_success = 1; end
      3: begin m_state = 3; m_success = 1; end
      default: begin m_state = 0; m_success = 1; end
    endcase
    m_balance = m_bal[acc];
  endtask

  task automatic apply(input int op, input int acc, input int pn, input int npn, input longint amt);
    model_step(op, acc, pn, npn, amt);
    bus.operation = 3'(op);
    bus.acc_num   = 4'(acc);
    bus.pin       = 16'(pn);
    bus.newPin    = 16'(npn);
    bus.amount    = 32'(amt);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.operation = 3'd0; bus.acc_num = 4'd0; bus.pin = 16'd0;
    bus.newPin = 16'd0; bus.amount = 32'd0; bus.language = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    tests++;
    if (bus.state !== 3'd7 || bus.balance !== 32'd0 || bus.success !== 1'b0) begin
      $display("FAIL reset: state=%0d bal=%0d succ=%0b want 7/0/0", bus.state, bus.balance, bus.success);
      fails++;
    end
    rst = 1'b1;
  endtask

  task automatic test_balance_deposit();
    apply(3, 1, 1234, 0, 0);
    tests++;
    if (bus.state !== 3'd3 || bus.balance !== 32'd1000 || bus.success !== 1'b1) begin
      $display("FAIL balance_acc1: state=%0d bal=%0d succ=%0b want 3/1000/1", bus.state, bus.balance, bus.success);
      fails++;
    end
    for (int c = 0; c < 2; c++) begin
      apply(5, 1, 1234, 0, 1000);
      tests++;
      if (bus.state !== 3'd5 || bus.balance !== 32'd2000 || bus.success !== 1'b1) begin
        $display("FAIL deposit_held cycle%0d: state=%0d bal=%0d succ=%0b want 5/2000/1", c, bus.state, bus.balance, bus.success);
        fails++;
      end
    end
  endtask

  task automatic test_all_accounts();
    int pins [10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
    for (int a = 2; a <= 10; a++) begin
      apply(3, a, pins[a-1], 0, 0);
      tests++;
      if (bus.state !== 3'd3 || bus.balance !== 32'd1000 || bus.success !== 1'b1) begin
        $display("FAIL balance_acc%0d: state=%0d bal=%0d succ=%0b want 3/1000/1", a, bus.state, bus.balance, bus.success);
        fails++;
      end
    end
  endtask

  task automatic test_lockout();
    for (int t = 0; t < 3; t++) begin
      apply(3, 1, 1111, 0, 0);
      tests++;
      if (bus.state !== 3'd6 || bus.balance !== 32'd0 || bus.success !== 1'b0) begin
        $display("FAIL wrong_pin try%0d: state=%0d bal=%0d succ=%0b want 6/0/0", t, bus.state, bus.balance, bus.success);
        fails++;
      end
    end
    apply(3, 1, 1234, 0, 0);
    tests++;
    if (bus.state !== 3'd6 || bus.balance !== 32'd0 || bus.success !== 1'b0) begin
      $display("FAIL locked_good_pin: state=%0d bal=%0d succ=%0b want 6/0/0", bus.state, bus.balance, bus.success);
      fails++;
    end
  endtask

  task automatic test_withdraw_pin();
    apply(1, 2, 2345, 0, 1500);
    tests++;
    if (bus.state !== 3'd6 || bus.balance !== 32'd1000 || bus.success !== 1'b0) begin
      $display("FAIL overdraw: state=%0d bal=%0d succ=%0b want 6/1000/0", bus.state, bus.balance, bus.success);
      fails++;
    end
    apply(2, 2, 2345, 4321, 0);
    tests++;
    if (bus.state !== 3'd2 || bus.success !== 1'b1) begin
      $display("FAIL chg_pin: state=%0d succ=%0b want 2/1", bus.state, bus.success);
      fails++;
    end
    apply(3, 2, 4321, 0, 0);
    tests++;
    if (bus.state !== 3'd3 || bus.balance !== 32'd1000 || bus.success !== 1'b1) begin
      $display("FAIL new_pin_balance: state=%0d bal=%0d succ=%0b want 3/1000/1", bus.state, bus.balance, bus.success);
      fails++;
    end
    apply(0, 2, 4321, 0, 0);
    apply(3, 2, 2345, 0, 0);
    tests++;
    if (bus.state !== 3'd6 || bus.success !== 1'b0) begin
      $display("FAIL old_pin_rejected: state=%0d succ=%0b want 6/0", bus.state, bus.success);
      fails++;
    end
  endtask

  task automatic test_boundaries();
    apply(1, 3, 3456, 0, 1000);
    tests++;
    if (bus.state !== 3'd1 || bus.balance !== 32'd0 || bus.success !== 1'b1) begin
      $display("FAIL withdraw_exact: state=%0d bal=%0d succ=%0b want 1/0/1", bus.state, bus.balance, bus.success);
      fails++;
    end
    apply(5, 3, 3456, 0, 64'hFFFF_FFFF);
    tests++;
    if (bus.state !== 3'd5 || bus.balance !== 32'hFFFF_FFFF || bus.success !== 1'b1) begin
      $display("FAIL deposit_to_max: state=%0d bal=%0h succ=%0b want 5/ffffffff/1", bus.state, bus.balance, bus.success);
      fails++;
    end
    apply(0, 3, 3456, 0, 0);
    apply(5, 3, 3456, 0, 1);
    tests++;
    if (bus.state !== 3'd6 || bus.balance !== 32'hFFFF_FFFF || bus.success !== 1'b0) begin
      $display("FAIL deposit_overflow: state=%0d bal=%0h succ=%0b want 6/ffffffff/0", bus.state, bus.balance, bus.success);
      fails++;
    end
    apply(2, 3, 3456, 10000, 0);
    tests++;
    if (bus.state !== 3'd6 || bus.success !== 1'b0) begin
      $display("FAIL pin_10000: state=%0d succ=%0b want 6/0", bus.state, bus.success);
      fails++;
    end
    apply(2, 3, 3456, 9999, 0);
    tests++;
    if (bus.state !== 3'd2 || bus.success !== 1'b1) begin
      $display("FAIL pin_9999: state=%0d succ=%0b want 2/1", bus.state, bus.success);
      fails++;
    end
    apply(6, 3, 9999, 0, 0);
    tests++;
    if (bus.state !== 3'd0 || bus.success !== 1'b1 || bus.balance !== 32'hFFFF_FFFF) begin
      $display("FAIL exit: state=%0d bal=%0h succ=%0b want 0/ffffffff/1", bus.state, bus.balance, bus.success);
      fails++;
    end
    apply(0, 3, 9999, 0, 0);
    tests++;
    if (bus.state !== 3'd0 || bus.success !== 1'b0) begin
      $display("FAIL nop: state=%0d succ=%0b want 0/0", bus.state, bus.success);
      fails++;
    end
    foreach (m_pin[a]) begin
      if (a == 0 || a == 11) begin
        apply(3, a, 1234, 0, 0);
        tests++;
        if (bus.state !== 3'd6 || bus.balance !== 32'd0 || bus.success !== 1'b0) begin
          $display("FAIL invalid_acc%0d: state=%0d bal=%0d succ=%0b want 6/0/0", a, bus.state, bus.balance, bus.success);
          fails++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply(5, 4, 4567, 0, 500);
    bus.operation = 3'd5; bus.acc_num = 4'd5; bus.pin = 16'd5678; bus.amount = 32'd700;
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.state !== 3'd7 || bus.balance !== 32'd0 || bus.success !== 1'b0) begin
      $display("FAIL async_reset: state=%0d bal=%0d succ=%0b want 7/0/0", bus.state, bus.balance, bus.success);
      fails++;
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(3, 4, 4567, 0, 0);
    tests++;
    if (bus.balance !== 32'd1000) begin
      $display("FAIL reset_restores_acc4: bal=%0d want 1000", bus.balance);
      fails++;
    end
    apply(3, 5, 5678, 0, 0);
    tests++;
    if (bus.balance !== 32'd1000) begin
      $display("FAIL reset_aborts_acc5: bal=%0d want 1000", bus.balance);
      fails++;
    end
  endtask

  task automatic test_random();
    int op, acc, pn, npn;
    longint amt;
    bit lang;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    op = 3; acc = 1; pn = 1234; npn = 0; amt = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        op  = $urandom_range(0, 7);
        acc = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) * $urandom_range(0, 1) : $urandom_range(1, 10);
        pn  = (acc >= 1 && acc <= 10 && $urandom_range(0, 4) != 0) ? m_pin[acc] : $urandom_range(0, 9999);
        npn = $urandom_range(0, 11000);
        amt = ($urandom_range(0, 4) == 0) ? longint'({32'b0, $urandom()}) : longint'($urandom_range(0, 2500));
      end
      lang = 1'($urandom_range(0, 1));
      bus.language = lang;
      apply(op, acc, pn, npn, amt);
      tests++;
      if (bus.state !== 3'(m_state) || bus.success !== m_success || bus.balance !== 32'(m_balance)
          || bus.language_q !== lang) begin
        $display("FAIL random[%0d] op=%0d acc=%0d: state=%0d succ=%0b bal=%0d lang=%0b want %0d/%0b/%0d/%0b",
                 n, op, acc, bus.state, bus.success, bus.balance, bus.language_q,
                 m_state, m_success, m_balance, lang);
        fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_balance_deposit();
    test_all_accounts();
    test_lockout();
    test_withdraw_pin();
    test_boundaries();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
